// File: rtl/bcd_scan_display.sv
// Samples a binary count once per display frame, converts it to BCD with a
// sequential double-dabble FSM and scans the digits onto a common-anode 7-segment display.
module bcd_scan_display #(
    parameter int N           = 4,
    parameter int DIGITS      = 4,
    parameter int REFRESH_DIV = 100000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N-1:0]      count_in,
    output logic [DIGITS-1:0] an,
    output logic [6:0]        seg,
    output logic              frame_tick,
    output logic              busy
);
    localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int CW = $clog2(N + 1);
    localparam int BW = 4 * DIGITS;
    localparam logic [DIGITS-1:0] AN_ONE = DIGITS'(1);

    typedef enum logic [1:0] {IDLE, CONVERT, COMMIT} state_t;

    state_t                   state, state_next;
    logic [PW-1:0]            pre;
    logic [IW-1:0]            idx;
    logic                     digit_tick;
    logic [CW-1:0]            step;
    logic [N-1:0]             shreg;
    logic [BW-1:0]            bcd, bcd_adj;
    logic [DIGITS-1:0][3:0]   disp;
    logic [DIGITS-1:0]        blank;
    logic                     upper_zero;

    function automatic logic [6:0] encode(input logic [3:0] v);
        case (v)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return 7'b0111111;
        endcase
    endfunction

    assign digit_tick = (pre == PW'(REFRESH_DIV - 1));
    assign frame_tick = digit_tick && (idx == IW'(DIGITS - 1));

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre <= '0;
            idx <= '0;
        end else if (digit_tick) begin
            pre <= '0;
            idx <= (idx == IW'(DIGITS - 1)) ? '0 : idx + 1'b1;
        end else begin
            pre <= pre + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // NOTE: combinational blocks assign a default first so no path leaves a latch behind.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (frame_tick) state_next = CONVERT;
            CONVERT: if (step == CW'(N - 1)) state_next = COMMIT;
            COMMIT:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy = (state != IDLE);
    end

    always_comb begin
        bcd_adj = bcd;
        for (int d = 0; d < DIGITS; d++) begin
            if (bcd[4*d +: 4] >= 4'd5) bcd_adj[4*d +: 4] = bcd[4*d +: 4] + 4'd3;
        end
    end

    // NOTE: disp is a small register bank, so it is reset with the rest; a RAM would not be.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg <= '0;
            bcd   <= '0;
            step  <= '0;
            disp  <= '0;
        end else begin
            case (state)
                IDLE: if (frame_tick) begin
                    shreg <= count_in;
                    bcd   <= '0;
                    step  <= '0;
                end
                CONVERT: begin
                    bcd   <= {bcd_adj[BW-2:0], shreg[N-1]};
                    shreg <= shreg << 1;
                    step  <= step + 1'b1;
                end
                COMMIT:  disp <= bcd;
                default: ;
            endcase
        end
    end

    // A digit is blank only when it and every more significant digit are zero.
    always_comb begin
        blank      = '0;
        upper_zero = 1'b1;
        for (int k = DIGITS - 1; k >= 1; k--) begin
            upper_zero = upper_zero && (disp[k] == 4'd0);
            blank[k]   = upper_zero;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            an  <= '1;
            seg <= 7'b1111111;
        end else begin
            an  <= ~(AN_ONE << idx);
            seg <= blank[idx] ? 7'b1111111 : encode(disp[idx]);
        end
    end
endmodule

// File: tb/tb_bcd_scan_display.sv
// Directed bench for bcd_scan_display with N=4, DIGITS=4, REFRESH_DIV=4 (16-cycle frame).
// cyc counts rising edges since the last reset release; outputs are sampled on the falling edge.
module tb_bcd_scan_display;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_0 = 7'b1000000;
    localparam logic [6:0] SEG_1 = 7'b1111001;
    localparam logic [6:0] SEG_2 = 7'b0100100;
    localparam logic [6:0] SEG_3 = 7'b0110000;
    localparam logic [6:0] SEG_5 = 7'b0010010;
    localparam logic [6:0] SEG_7 = 7'b1111000;
    localparam logic [6:0] SEG_9 = 7'b0010000;
    localparam logic [3:0][3:0] AN_EXP = {4'b0111, 4'b1011, 4'b1101, 4'b1110};

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] count_in;
    logic [3:0] an;
    logic [6:0] seg;
    logic       frame_tick;
    logic       busy;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always #5 clk = ~clk;

    bcd_scan_display #(.N(4), .DIGITS(4), .REFRESH_DIV(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .count_in   (count_in),
        .an         (an),
        .seg        (seg),
        .frame_tick (frame_tick),
        .busy       (busy)
    );

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    // Waits for the frame_tick sample, captures val, then records busy and one sample of each digit.
    task automatic capture_and_read(input logic [3:0] val, input bit do_toggle, input logic [3:0] toggle_val,
                                    output logic ft, output logic [5:0] busy_vec, output logic [6:0] seg_before,
                                    output logic [3:0][6:0] segs, output logic [3:0][3:0] ans);
        count_in = val;
        while (cyc % 16 != 15) tick();
        ft = frame_tick;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (do_toggle && i == 1) count_in = toggle_val;
            busy_vec[i] = busy;
        end
        seg_before = seg;
        tick();
        segs[1] = seg; ans[1] = an;
        repeat (4) tick();
        segs[2] = seg; ans[2] = an;
        repeat (4) tick();
        segs[3] = seg; ans[3] = an;
        repeat (4) tick();
        segs[0] = seg; ans[0] = an;
    endtask

    task automatic test_reset(input bit mid_frame);
        if (mid_frame) begin
            #2 rst = 1'b1;
            #1;
        end else begin
            rst = 1'b1;
            @(negedge clk);
            @(negedge clk);
        end
        checks++; if (an !== 4'b1111) begin errors++; $display("FAIL reset_an: got %b expected 1111", an); end
        checks++; if (seg !== SEG_BLANK) begin errors++; $display("FAIL reset_seg: got %b expected %b", seg, SEG_BLANK); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (frame_tick !== 1'b0) begin errors++; $display("FAIL reset_frame_tick: got %b expected 0", frame_tick); end
        @(negedge clk);
        rst = 1'b0;
        cyc = 0;
        for (int c = 0; c < 16; c++) begin
            if (c > 0) tick();
            checks++;
            if (frame_tick !== (cyc == 15)) begin
                errors++; $display("FAIL reset_first_frame_tick cycle %0d: got %b expected %b", cyc + 1, frame_tick, cyc == 15);
            end
            checks++;
            if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy_idle cycle %0d: got %b expected 0", cyc + 1, busy); end
            if (cyc == 1) begin
                checks++; if (an !== 4'b1110) begin errors++; $display("FAIL reset_first_an: got %b expected 1110", an); end
                checks++; if (seg !== SEG_0) begin errors++; $display("FAIL reset_first_seg: got %b expected %b", seg, SEG_0); end
            end
        end
    endtask

    task automatic test_convert_13();
        logic ft; logic [5:0] bv; logic [6:0] sb; logic [3:0][6:0] s; logic [3:0][3:0] a;
        logic [3:0][6:0] exp_seg;
        exp_seg = {SEG_BLANK, SEG_BLANK, SEG_1, SEG_3};
        capture_and_read(4'd13, 1'b0, 4'd0, ft, bv, sb, s, a);
        checks++; if (ft !== 1'b1) begin errors++; $display("FAIL conv13_frame_tick: got %b expected 1", ft); end
        checks++; if (bv !== 6'b011111) begin errors++; $display("FAIL conv13_busy: got %b expected 011111", bv); end
        checks++; if (sb !== SEG_BLANK) begin errors++; $display("FAIL conv13_latency: got %b expected %b", sb, SEG_BLANK); end
        for (int d = 0; d < 4; d++) begin
            checks++;
            if (s[d] !== exp_seg[d]) begin errors++; $display("FAIL conv13_digit%0d_seg: got %b expected %b", d, s[d], exp_seg[d]); end
            checks++;
            if (a[d] !== AN_EXP[d]) begin errors++; $display("FAIL conv13_digit%0d_an: got %b expected %b", d, a[d], AN_EXP[d]); end
        end
    endtask

    task automatic test_max_and_zero();
        logic ft; logic [5:0] bv; logic [6:0] sb; logic [3:0][6:0] s; logic [3:0][3:0] a;
        logic [3:0][6:0] exp_seg;
        exp_seg = {SEG_BLANK, SEG_BLANK, SEG_1, SEG_5};
        capture_and_read(4'd15, 1'b0, 4'd0, ft, bv, sb, s, a);
        checks++; if (bv !== 6'b011111) begin errors++; $display("FAIL max_busy: got %b expected 011111", bv); end
        for (int d = 0; d < 4; d++) begin
            checks++;
            if (s[d] !== exp_seg[d]) begin errors++; $display("FAIL max_digit%0d_seg: got %b expected %b", d, s[d], exp_seg[d]); end
        end
        exp_seg = {SEG_BLANK, SEG_BLANK, SEG_BLANK, SEG_0};
        capture_and_read(4'd0, 1'b0, 4'd0, ft, bv, sb, s, a);
        checks++; if (sb !== SEG_1) begin errors++; $display("FAIL zero_before_commit: got %b expected %b", sb, SEG_1); end
        for (int d = 0; d < 4; d++) begin
            checks++;
            if (s[d] !== exp_seg[d]) begin errors++; $display("FAIL zero_digit%0d_seg: got %b expected %b", d, s[d], exp_seg[d]); end
        end
    endtask

    task automatic test_change_during_convert();
        logic ft; logic [5:0] bv; logic [6:0] sb; logic [3:0][6:0] s; logic [3:0][3:0] a;
        logic [3:0][6:0] exp_seg;
        exp_seg = {SEG_BLANK, SEG_BLANK, SEG_BLANK, SEG_7};
        capture_and_read(4'd7, 1'b1, 4'd9, ft, bv, sb, s, a);
        for (int d = 0; d < 4; d++) begin
            checks++;
            if (s[d] !== exp_seg[d]) begin errors++; $display("FAIL change_digit%0d_seg: got %b expected %b", d, s[d], exp_seg[d]); end
        end
        exp_seg = {SEG_BLANK, SEG_BLANK, SEG_BLANK, SEG_9};
        capture_and_read(4'd9, 1'b0, 4'd0, ft, bv, sb, s, a);
        for (int d = 0; d < 4; d++) begin
            checks++;
            if (s[d] !== exp_seg[d]) begin errors++; $display("FAIL change_next_digit%0d_seg: got %b expected %b", d, s[d], exp_seg[d]); end
        end
    endtask

    task automatic test_reset_during_convert();
        logic ft; logic [5:0] bv; logic [6:0] sb; logic [3:0][6:0] s; logic [3:0][3:0] a;
        logic [3:0][6:0] exp_seg;
        count_in = 4'd12;
        while (cyc % 16 != 15) tick();
        tick();
        tick();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rstconv_busy_before: got %b expected 1", busy); end
        rst = 1'b1;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstconv_busy_in_reset: got %b expected 0", busy); end
        @(negedge clk);
        rst = 1'b0;
        cyc = 0;
        for (int c = 1; c < 16; c++) begin
            tick();
            checks++;
            if (busy !== 1'b0) begin errors++; $display("FAIL rstconv_busy_after cycle %0d: got %b expected 0", cyc + 1, busy); end
            if (cyc == 2) begin
                checks++; if (seg !== SEG_0) begin errors++; $display("FAIL rstconv_disp_digit0: got %b expected %b", seg, SEG_0); end
            end
            if (cyc == 6) begin
                checks++; if (seg !== SEG_BLANK) begin errors++; $display("FAIL rstconv_disp_digit1: got %b expected %b", seg, SEG_BLANK); end
            end
        end
        exp_seg = {SEG_BLANK, SEG_BLANK, SEG_1, SEG_2};
        capture_and_read(4'd12, 1'b0, 4'd0, ft, bv, sb, s, a);
        checks++; if (ft !== 1'b1) begin errors++; $display("FAIL rstconv_frame_tick: got %b expected 1", ft); end
        checks++; if (sb !== SEG_BLANK) begin errors++; $display("FAIL rstconv_latency: got %b expected %b", sb, SEG_BLANK); end
        for (int d = 0; d < 4; d++) begin
            checks++;
            if (s[d] !== exp_seg[d]) begin errors++; $display("FAIL rstconv_digit%0d_seg: got %b expected %b", d, s[d], exp_seg[d]); end
        end
    endtask

    task automatic test_scan_order();
        logic [3:0] exp_an;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        cyc = 0;
        for (int c = 0; c <= 32; c++) begin
            if (c > 0) tick();
            if (cyc < 32) begin
                checks++;
                if (frame_tick !== (cyc % 16 == 15)) begin
                    errors++; $display("FAIL scan_frame_tick cycle %0d: got %b expected %b", cyc + 1, frame_tick, cyc % 16 == 15);
                end
            end
            if (cyc >= 1) begin
                exp_an = AN_EXP[((cyc - 1) / 4) % 4];
                checks++;
                if (an !== exp_an) begin errors++; $display("FAIL scan_an edge %0d: got %b expected %b", cyc, an, exp_an); end
                checks++;
                if ($countones(~an) != 1) begin errors++; $display("FAIL scan_one_cold edge %0d: got %b expected one zero bit", cyc, an); end
            end
        end
    endtask

    initial begin
        count_in = 4'd0;
        test_reset(1'b0);
        test_convert_13();
        test_reset(1'b1);
        test_max_and_zero();
        test_change_during_convert();
        test_reset_during_convert();
        test_scan_order();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not reach its end, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/bcd_scan_display.md
# bcd_scan_display

Display back end for the counter stage. It samples the N-bit count once per display frame. A sequential double-dabble FSM converts the sample to BCD digits. The block then time-multiplexes the digits onto a common-anode 7-segment display with leading-zero blanking. It sits directly downstream of the counter top and consumes its `fullNum` bus on `count_in`.

## Interface
- `N`, 4: width of `count_in` (binary, unsigned).
- `DIGITS`, 4: number of display digits. Legal only if 10^DIGITS > 2^N − 1.
- `REFRESH_DIV`, 100000: clock cycles each digit is driven. Must be ≥ 2.
- Legality constraint: DIGITS·REFRESH_DIV > N + 2.

- `clk`, input, 1: single clock. All state is on the rising edge.
- `rst`, input, 1: reset. Asynchronous, active-high.
- `count_in`, input, N: binary value to display, from the counter stage.
- `an`, output, DIGITS: digit enables, active-low, registered.
- `seg`, output, 7: segments {g,f,e,d,c,b,a}, active-low, registered.
- `frame_tick`, output, 1: one-cycle pulse at the end of each display frame.
- `busy`, output, 1: high while a conversion is in progress.

## Operation
- **Prescaler `pre`**
  - Counts 0..REFRESH_DIV−1, then wraps to 0.
  - `digit_tick` = (`pre` == REFRESH_DIV−1).
- **Digit index `idx`**
  - Counts 0..DIGITS−1 and advances on `digit_tick`.
  - Wraps from DIGITS−1 to 0.
- **`frame_tick`** is high when `digit_tick` is high and `idx` == DIGITS−1.
- **Converter FSM**
  - IDLE → CONVERT on `frame_tick`. At that edge `count_in` is captured into a shift register and the BCD accumulator is cleared.
  - CONVERT runs exactly N cycles. Each cycle adds 3 to every BCD nibble ≥ 5, then shifts left 1, taking the shift register MSB in.
  - After the Nth cycle, CONVERT → COMMIT.
  - COMMIT runs 1 cycle. It copies the accumulator into the display registers `disp[DIGITS-1:0][3:0]`, then returns to IDLE.
  - `busy` = (state ≠ IDLE).
  - A `frame_tick` can never arrive while `busy` is high; the legality constraint guarantees this.
  - Changes on `count_in` outside the capture edge are ignored.
- **Blanking**
  - Digit k (k ≥ 1) is blanked when `disp[j]` == 0 for every j ≥ k.
  - Digit 0 is never blanked.
- **Output registers**
  - Each edge: `an` ← one-cold at bit `idx`.
  - Each edge: `seg` ← encode(`disp[idx]`), or 7'b1111111 if digit `idx` is blanked.
  - A blanked digit keeps its anode active.
- **Encoding** (seg {g..a}):
  - 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000, 4 = 0011001
  - 5 = 0010010, 6 = 0000010, 7 = 1111000, 8 = 0000000, 9 = 0010000
  - Any nibble > 9 (unreachable) encodes as 7'b0111111, the "-" pattern.

## Timing
- **Reset values** (asynchronous, while `rst` = 1):
  - `pre` = 0, `idx` = 0, state = IDLE.
  - `disp` = all zero, shift and BCD registers = 0.
  - `an` = all 1s (display dark), `seg` = 7'b1111111.
  - `frame_tick` = 0, `busy` = 0.
- **First edge after reset release:** `an` = …1110 and `seg` = 1000000 (digit 0 shows "0", other digits blanked).
- **Frame length:** DIGITS·REFRESH_DIV cycles. The first `frame_tick` occurs on cycle DIGITS·REFRESH_DIV after reset release (1-based).
- **Update latency:** `count_in` is sampled at the `frame_tick` edge. The new digits reach `an`/`seg` N+2 edges later:
  - N cycles in CONVERT;
  - 1 cycle in COMMIT;
  - 1 cycle for the output register.
- **Reset mid-conversion:** the captured value is discarded. The next conversion occurs only at the next `frame_tick`.
- **`frame_tick` and `digit_tick` coincide:** `idx` wraps to 0 and the capture happens on the same edge.
- **Count at 2^N−1:** converts exactly. There is no saturation path.

## Test plan
All scenarios use N = 4, DIGITS = 4, REFRESH_DIV = 4 (frame = 16 cycles).

1. **Reset.** Assert `rst` mid-frame with `disp` showing 13 → `an` = 1111 and `seg` = 1111111 immediately. After release: `an` = 1110, `seg` = 1000000, and the first `frame_tick` at cycle 16.
2. **Conversion of 13.** `count_in` = 13, then wait 1 frame plus 6 cycles → `busy` high for exactly 5 cycles after `frame_tick`. Then:
   - digit 0 `seg` = 0110000 ("3");
   - digit 1 `seg` = 1111001 ("1");
   - digits 2 and 3 `seg` = 1111111 with their anodes still scanned.
3. **Maximum and zero.** `count_in` = 15 → digits 1 and 0 show 1111001 and 0010010. Next frame, `count_in` = 0 → only digit 0 lit, showing 1000000.
4. **Input change during CONVERT.** `count_in` 7 → 9, toggled 2 cycles after `frame_tick` → displayed value is 7 (1111000) for that frame. The display shows 9 only after the following frame's commit.
5. **Reset during CONVERT.** Assert `rst` on cycle 2 of CONVERT with `count_in` = 12 → after release, `disp` = 0 and `busy` = 0. "12" appears only after the next `frame_tick` + 6 cycles.
6. **Scan order.** Over 32 cycles, check `an` steps 1110 → 1101 → 1011 → 0111, each held exactly 4 cycles, with exactly one 0 bit at all times out of reset. `frame_tick` is high only on cycles 16 and 32.
